// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: debounces two active-low keys and steps a registered pattern at a prescaled tick.
// Optional COUNT mode is compiled in with `define LED_PATTERN_COUNT_MODE_EN.
module led_pattern_ctrl #(
    parameter int LED_W           = 10,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       key,
    output logic [LED_W-1:0] led,
    output logic [2:0]       mode,
    output logic             run
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_SHIFT_L = 3'd1,
        MODE_SHIFT_R = 3'd2,
        MODE_BLINK   = 3'd3,
        MODE_COUNT   = 3'd4
    } mode_t;

    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic [1:0]        stable_q, stable_d;
    logic [1:0]        press_q, press_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [LED_W-1:0]  led_q, led_d;
    mode_t             mode_q, mode_d;
    logic              run_q, run_d;

    logic [1:0]        pressed;
    logic              tick;
    mode_t             next_mode;

    function automatic logic [LED_W-1:0] start_pattern(input mode_t m);
        logic [LED_W-1:0] p;
        p = '0;
        case (m)
            MODE_SHIFT_L: p = LED_W'(1);
            MODE_SHIFT_R: p = {1'b1, {(LED_W-1){1'b0}}};
            MODE_BLINK: begin
                for (int i = 0; i < LED_W; i++) begin
                    p[i] = ((i % 2) == 0);
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Synchronise, debounce and detect the released-to-pressed transition of each key.
    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
        pressed = ~sync2_q;
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (pressed[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = pressed[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_d = stable_d & ~stable_q;
    end

    always_comb begin
        next_mode = MODE_IDLE;
        case (mode_q)
            MODE_IDLE:    next_mode = MODE_SHIFT_L;
            MODE_SHIFT_L: next_mode = MODE_SHIFT_R;
            MODE_SHIFT_R: next_mode = MODE_BLINK;
`ifdef LED_PATTERN_COUNT_MODE_EN
            MODE_BLINK:   next_mode = MODE_COUNT;
`else
            MODE_BLINK:   next_mode = MODE_IDLE;
`endif
            default:      next_mode = MODE_IDLE;
        endcase
    end

    // A mode change (key 0, alone or with key 1) reloads the start pattern and overrides any tick.
    always_comb begin
        mode_d     = mode_q;
        run_d      = run_q;
        led_d      = led_q;
        tick_cnt_d = tick_cnt_q;
        tick       = run_q && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        if (press_q[0]) begin
            mode_d     = press_q[1] ? MODE_IDLE : next_mode;
            run_d      = press_q[1] ? 1'b1 : run_q;
            led_d      = start_pattern(mode_d);
            tick_cnt_d = '0;
        end else begin
            if (run_q) begin
                tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
            end
            if (tick) begin
                case (mode_q)
                    MODE_SHIFT_L: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    MODE_SHIFT_R: led_d = {led_q[0], led_q[LED_W-1:1]};
                    MODE_BLINK:   led_d = ~led_q;
`ifdef LED_PATTERN_COUNT_MODE_EN
                    MODE_COUNT:   led_d = led_q + 1'b1;
`endif
                    default:      led_d = led_q;
                endcase
            end
            if (press_q[1]) begin
                run_d = ~run_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            cnt_q[0]   <= '0;
            cnt_q[1]   <= '0;
            stable_q   <= '0;
            press_q    <= '0;
            tick_cnt_q <= '0;
            led_q      <= '0;
            mode_q     <= MODE_IDLE;
            run_q      <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            stable_q   <= stable_d;
            press_q    <= press_d;
            tick_cnt_q <= tick_cnt_d;
            led_q      <= led_d;
            mode_q     <= mode_d;
            run_q      <= run_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign run  = run_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: directed vector table, random key traffic against a
// step-count reference model, and hand-written latency / async-reset sequences.
module tb_led_pattern_ctrl;

    localparam int LED_W = 10;
    localparam int DB    = 4;
    localparam int TD    = 8;
`ifdef LED_PATTERN_COUNT_MODE_EN
    localparam int NUM_MODES = 5;
`else
    localparam int NUM_MODES = 4;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       key;
    logic [LED_W-1:0] led;
    logic [2:0]       mode;
    logic             run;

    int checks   = 0;
    int failures = 0;

    // Reference model state: mode, run flag, ticks taken since the last mode entry and position inside the tick period.
    int         mMode;
    bit         mRun;
    int         mSteps;
    int         mPhase;
    bit [1:0]   mPress;
    bit [1:0]   mStable;
    int         mCnt [2];
    logic [1:0] mPipe [$];

    typedef struct {
        logic [1:0]       k;
        int               n;
        logic [LED_W-1:0] eLed;
        int               eMode;
        bit               eRun;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    led_pattern_ctrl #(
        .LED_W(LED_W),
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key(key),
        .led(led),
        .mode(mode),
        .run(run)
    );

    function automatic int nextMode(input int m);
        return (m + 1) % NUM_MODES;
    endfunction

    // The LED value is a pure function of the current mode and how many ticks have elapsed since entering it.
    function automatic logic [LED_W-1:0] expLed(input int m, input int s);
        logic [LED_W-1:0] e;
        case (m)
            1:       e = LED_W'(1) << (s % LED_W);
            2:       e = LED_W'(1) << (LED_W - 1 - (s % LED_W));
            3:       e = ((s % 2) == 0) ? 10'h155 : 10'h2AA;
            4:       e = LED_W'(s % 1024);
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic modelReset();
        mMode   = 0;
        mRun    = 1'b1;
        mSteps  = 0;
        mPhase  = 0;
        mPress  = 2'b00;
        mStable = 2'b00;
        mCnt[0] = 0;
        mCnt[1] = 0;
        mPipe.delete();
        mPipe.push_back(2'b11);
        mPipe.push_back(2'b11);
    endtask

    task automatic modelEdge(input logic [1:0] k);
        bit         c0;
        bit         c1;
        bit         p;
        logic [1:0] s;
        c0 = mPress[0];
        c1 = mPress[1];
        if (c0) begin
            mMode  = c1 ? 0 : nextMode(mMode);
            if (c1) mRun = 1'b1;
            mSteps = 0;
            mPhase = 0;
        end else begin
            if (mRun) begin
                if (mPhase == TD - 1) begin
                    mPhase = 0;
                    mSteps++;
                end else begin
                    mPhase++;
                end
            end
            if (c1) mRun = !mRun;
        end
        s = mPipe.pop_front();
        mPipe.push_back(k);
        for (int i = 0; i < 2; i++) begin
            p = ~s[i];
            mPress[i] = 1'b0;
            if (p != mStable[i]) begin
                if (mCnt[i] == DB - 1) begin
                    mStable[i] = p;
                    mCnt[i]    = 0;
                    mPress[i]  = p;
                end else begin
                    mCnt[i]++;
                end
            end else begin
                mCnt[i] = 0;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [LED_W-1:0] eLed, input int eMode, input bit eRun);
        checks++;
        if (led !== eLed || mode !== 3'(eMode) || run !== eRun) begin
            failures++;
            $display("[TB] FAIL %s: got led=%h mode=%0d run=%0d, expected led=%h mode=%0d run=%0d",
                     name, led, mode, run, eLed, eMode, eRun);
        end
    endtask

    task automatic checkMode(input string name, input int eMode);
        checks++;
        if (mode !== 3'(eMode)) begin
            failures++;
            $display("[TB] FAIL %s: got mode=%0d, expected mode=%0d", name, mode, eMode);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] k, input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            key = k;
            @(posedge clk);
            modelEdge(k);
            #1;
            checkOutput(tag, expLed(mMode, mSteps), mMode, mRun);
        end
    endtask

    task automatic pushVec(input logic [1:0] k, input int n, input logic [LED_W-1:0] l, input int m, input bit r);
        vec_t v;
        v.k = k; v.n = n; v.eLed = l; v.eMode = m; v.eRun = r;
        tbl.push_back(v);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        key   = 2'b11;
        modelReset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            key = 2'($urandom_range(0, 3));
        end
        #1;
        checkOutput("in_reset", '0, 0, 1'b1);
        @(negedge clk);
        key = 2'b11;
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("after_reset", '0, 0, 1'b1);
    endtask

    initial begin
        int m0;
        bit r0;
        rst_n = 1'b0;
        key   = 2'b11;
        doReset();

`ifndef LED_PATTERN_COUNT_MODE_EN
        pushVec(2'b11,  5, 10'h000, 0, 1);
        pushVec(2'b10,  3, 10'h000, 0, 1);
        pushVec(2'b11, 10, 10'h000, 0, 1);
        pushVec(2'b10, 20, 10'h002, 1, 1);
        pushVec(2'b11, 10, 10'h004, 1, 1);
        pushVec(2'b11, 80, 10'h004, 1, 1);
        pushVec(2'b10, 10, 10'h200, 2, 1);
        pushVec(2'b11, 10, 10'h100, 2, 1);
        pushVec(2'b11, 80, 10'h100, 2, 1);
        pushVec(2'b10, 10, 10'h155, 3, 1);
        pushVec(2'b11, 10, 10'h2AA, 3, 1);
        pushVec(2'b01, 10, 10'h155, 3, 0);
        pushVec(2'b11, 50, 10'h155, 3, 0);
        pushVec(2'b01, 10, 10'h155, 3, 1);
        pushVec(2'b11,  2, 10'h2AA, 3, 1);
        pushVec(2'b10, 10, 10'h000, 0, 1);
        pushVec(2'b11, 10, 10'h000, 0, 1);
        pushVec(2'b10, 10, 10'h001, 1, 1);
        pushVec(2'b11, 10, 10'h002, 1, 1);
        pushVec(2'b10, 10, 10'h200, 2, 1);
        pushVec(2'b11, 10, 10'h100, 2, 1);
        pushVec(2'b01, 10, 10'h080, 2, 0);
        pushVec(2'b11, 10, 10'h080, 2, 0);
        pushVec(2'b00, 10, 10'h000, 0, 1);
        pushVec(2'b11, 10, 10'h000, 0, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].k, tbl[i].n, "model");
            checkOutput($sformatf("row%0d", i), tbl[i].eLed, tbl[i].eMode, tbl[i].eRun);
        end
`endif

        for (int i = 0; i < 250; i++) begin
            logic [1:0] k;
            int n;
            k = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 4) == 0) n = $urandom_range(10, 40);
            applyStimulus(k, n, "random");
        end

        // Exact key-to-output latency, then a long hold must not repeat the event.
        applyStimulus(2'b11, 40, "settle");
        m0 = mMode;
        r0 = mRun;
        applyStimulus(2'b10, 6, "latency_wait");
        checkMode("latency_edge6", m0);
        applyStimulus(2'b10, 1, "latency_edge");
        checkOutput("latency_edge7", expLed(nextMode(m0), 0), nextMode(m0), r0);
        applyStimulus(2'b10, 30, "held_key");
        checkMode("single_event", nextMode(m0));

        // Asynchronous reset between clock edges while shifting left.
        applyStimulus(2'b11, 20, "settle");
        for (int j = 0; j < 6 && mMode != 1; j++) begin
            applyStimulus(2'b10, 10, "to_shift_l");
            applyStimulus(2'b11, 10, "to_shift_l");
        end
        applyStimulus(2'b11, 25, "shift_l_run");
        checkMode("in_shift_l", 1);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", '0, 0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(2'b11, 10, "post_reset");

`ifdef LED_PATTERN_COUNT_MODE_EN
        for (int j = 0; j < 8 && mMode != 4; j++) begin
            applyStimulus(2'b10, 10, "to_count");
            applyStimulus(2'b11, 10, "to_count");
        end
        checkMode("in_count", 4);
        applyStimulus(2'b11, 8300, "count_wrap");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
